// File: rtl/fmul_pipe.sv
// Pipelined IEEE-754 single-precision multiplier, flush-to-zero, round-to-nearest-even.
// Define FMUL_PIPE_SPECIAL_EN to enable NaN/inf handling and overflow saturation to inf.
module fmul_pipe #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      x1,
  input  logic [31:0]      x2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      y,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [1:0] SpNone = 2'd0;
  localparam logic [1:0] SpNan  = 2'd1;
  localparam logic [1:0] SpInf  = 2'd2;

  typedef struct packed {
    logic        sign;
    logic        zero;
    logic [1:0]  spec;
    logic [9:0]  esum;
    logic [29:0] pp_hi;
    logic [41:0] pp_lo;
  } pp_t;

  typedef struct packed {
    logic        sign;
    logic        zero;
    logic [1:0]  spec;
    logic [9:0]  esum;
    logic [47:0] prod;
  } sum_t;

  typedef struct packed {
    logic        sign;
    logic        zero;
    logic [1:0]  spec;
    logic [9:0]  exp;
    logic [22:0] mant;
  } rnd_t;

  function automatic sum_t f_sum(pp_t s);
    sum_t r;
    r.sign = s.sign;
    r.zero = s.zero;
    r.spec = s.spec;
    r.esum = s.esum;
    r.prod = {s.pp_hi, 18'b0} + {6'b0, s.pp_lo};
    return r;
  endfunction

  function automatic rnd_t f_rnd(sum_t s);
    rnd_t        r;
    logic        norm, g, rb, st, up;
    logic [22:0] mant;
    logic [23:0] mr;
    norm = s.prod[47];
    mant = norm ? s.prod[46:24] : s.prod[45:23];
    g    = norm ? s.prod[23] : s.prod[22];
    rb   = norm ? s.prod[22] : s.prod[21];
    st   = norm ? |s.prod[21:0] : |s.prod[20:0];
    up   = g & (rb | st | mant[0]);
    // Carry out of mr leaves mr[22:0] all-zero, which is the renormalised mantissa.
    mr     = {1'b0, mant} + {23'b0, up};
    r.sign = s.sign;
    r.zero = s.zero;
    r.spec = s.spec;
    r.exp  = s.esum + {9'b0, norm} + {9'b0, mr[23]} - 10'd127;
    r.mant = mr[22:0];
    return r;
  endfunction

  function automatic logic [31:0] f_pack(rnd_t r);
    logic [31:0] res;
    logic        uflow;
    uflow = r.exp[9] | (r.exp == 10'd0);
    res   = {r.sign, r.exp[7:0], r.mant};
    if (r.spec == SpNan) begin
      res = 32'h7FC0_0000;
    end else if (r.spec == SpInf) begin
      res = {r.sign, 8'hFF, 23'b0};
    end else if (r.zero | uflow) begin
      res = {r.sign, 31'b0};
`ifdef FMUL_PIPE_SPECIAL_EN
    end else if (r.exp >= 10'd255) begin
      res = {r.sign, 8'hFF, 23'b0};
`endif
    end
    return res;
  endfunction

  logic                 stall, en;
  logic [LATENCY-1:0]   valid_q;
  logic [TAG_W-1:0]     tag_q [LATENCY];
  logic [31:0]          y_q;
  logic [23:0]          ma, mb;
  pp_t                  pp_d, pp_q;

  assign stall    = out_valid & ~out_ready;
  assign en       = ~stall;
  assign in_ready = en;
  assign ma       = {1'b1, x1[22:0]};
  assign mb       = {1'b1, x2[22:0]};

`ifdef FMUL_PIPE_SPECIAL_EN
  logic nan1, nan2, inf1, inf2, zer1, zer2;
  assign nan1 = (x1[30:23] == 8'hFF) & (x1[22:0] != 23'd0);
  assign nan2 = (x2[30:23] == 8'hFF) & (x2[22:0] != 23'd0);
  assign inf1 = (x1[30:23] == 8'hFF) & (x1[22:0] == 23'd0);
  assign inf2 = (x2[30:23] == 8'hFF) & (x2[22:0] == 23'd0);
  assign zer1 = (x1[30:23] == 8'd0);
  assign zer2 = (x2[30:23] == 8'd0);
`endif

  always_comb begin
    pp_d       = '0;
    pp_d.sign  = x1[31] ^ x2[31];
    pp_d.zero  = (x1[30:23] == 8'd0) | (x2[30:23] == 8'd0);
    pp_d.spec  = SpNone;
    pp_d.esum  = {2'b0, x1[30:23]} + {2'b0, x2[30:23]};
    pp_d.pp_hi = {6'b0, ma} * {24'b0, mb[23:18]};
    pp_d.pp_lo = {18'b0, ma} * {24'b0, mb[17:0]};
`ifdef FMUL_PIPE_SPECIAL_EN
    if (nan1 | nan2 | (inf1 & zer2) | (inf2 & zer1)) begin
      pp_d.spec = SpNan;
    end else if (inf1 | inf2) begin
      pp_d.spec = SpInf;
    end
`endif
  end

  // Stage data only loads behind a valid op, so y holds its last result across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      pp_q <= '0;
    end else if (en && in_valid) begin
      pp_q <= pp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < int'(LATENCY); k++) tag_q[k] <= '0;
    end else if (en) begin
      valid_q <= {valid_q[LATENCY-2:0], in_valid};
      if (in_valid) tag_q[0] <= in_tag;
      for (int k = 1; k < int'(LATENCY); k++) begin
        if (valid_q[k-1]) tag_q[k] <= tag_q[k-1];
      end
    end
  end

  if (LATENCY == 2) begin : g_lat2
    always_ff @(posedge clk) begin
      if (rst) begin
        y_q <= '0;
      end else if (en && valid_q[0]) begin
        y_q <= f_pack(f_rnd(f_sum(pp_q)));
      end
    end
  end else if (LATENCY == 3) begin : g_lat3
    sum_t sum_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        sum_q <= '0;
        y_q   <= '0;
      end else if (en) begin
        if (valid_q[0]) sum_q <= f_sum(pp_q);
        if (valid_q[1]) y_q   <= f_pack(f_rnd(sum_q));
      end
    end
  end else begin : g_lat4
    sum_t sum_q;
    rnd_t rnd_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        sum_q <= '0;
        rnd_q <= '0;
        y_q   <= '0;
      end else if (en) begin
        if (valid_q[0]) sum_q <= f_sum(pp_q);
        if (valid_q[1]) rnd_q <= f_rnd(sum_q);
        if (valid_q[2]) y_q   <= f_pack(rnd_q);
      end
    end
  end

  assign y         = y_q;
  assign out_tag   = tag_q[LATENCY-1];
  assign out_valid = valid_q[LATENCY-1];

endmodule
